// File: rtl/game_pkg.sv
// Shared definitions for the binary quiz game: FSM states, LFSR constants and the
// blank segment pattern.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        RESULT = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [6:0]  SEG_BLANK = 7'h00;

    // Right-shifting Galois step; a non-zero state never maps to zero.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/sevenseg_decoder.sv
// Hex nibble to seven-segment pattern, segments ordered {g,f,e,d,c,b,a}, active-high.
module sevenseg_decoder
    import game_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        unique case (i_hex)
            4'h0: o_seg = 7'h3F;
            4'h1: o_seg = 7'h06;
            4'h2: o_seg = 7'h5B;
            4'h3: o_seg = 7'h4F;
            4'h4: o_seg = 7'h66;
            4'h5: o_seg = 7'h6D;
            4'h6: o_seg = 7'h7D;
            4'h7: o_seg = 7'h07;
            4'h8: o_seg = 7'h7F;
            4'h9: o_seg = 7'h6F;
            4'hA: o_seg = 7'h77;
            4'hB: o_seg = 7'h7C;
            4'hC: o_seg = 7'h39;
            4'hD: o_seg = 7'h5E;
            4'hE: o_seg = 7'h79;
            4'hF: o_seg = 7'h71;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/binary_quiz_core.sv
// Game engine: input synchronisers, target LFSR, round/result timers, game FSM and a
// multiplexed hex display of the score (idle) or the target (in a round).
module binary_quiz_core
    import game_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DIGITS       = 2,
    parameter int SCORE_W      = 8,
    parameter int ROUND_TICKS  = 1000,
    parameter int RESULT_TICKS = 500,
    parameter int SCAN_DIV     = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   sw,
    input  logic               start,
    input  logic               submit,
    output logic [6:0]         seg,
    output logic [DIGITS-1:0]  dig_sel,
    output logic               led_ok,
    output logic               led_fail,
    output logic [SCORE_W-1:0] score,
    output logic               playing
);

    localparam int TIMER_W = (ROUND_TICKS  > 1) ? $clog2(ROUND_TICKS)  : 1;
    localparam int HOLD_W  = (RESULT_TICKS > 1) ? $clog2(RESULT_TICKS) : 1;
    localparam int SCAN_W  = (SCAN_DIV     > 1) ? $clog2(SCAN_DIV)     : 1;
    localparam int DIG_W   = (DIGITS       > 1) ? $clog2(DIGITS)       : 1;
    localparam int DISP_W  = 4 * DIGITS;
    localparam int EXT_W   = (DISP_W >= SCORE_W && DISP_W >= WIDTH) ? DISP_W :
                             (SCORE_W >= WIDTH) ? SCORE_W : WIDTH;

    logic [WIDTH-1:0]   r_sw_meta, r_sw_sync;
    logic [1:0]         r_start_sync, r_submit_sync;
    logic               r_start_prev, r_submit_prev;
    logic               w_start_edge, w_submit_edge;
    logic [15:0]        r_lfsr;
    logic [WIDTH-1:0]   w_new_target;

    state_t             r_state, w_state;
    logic [SCORE_W-1:0] r_score, w_score;
    logic [WIDTH-1:0]   r_target, w_target;
    logic [TIMER_W-1:0] r_timer, w_timer;
    logic [HOLD_W-1:0]  r_hold, w_hold;
    logic               r_led_ok, w_led_ok, r_led_fail, w_led_fail;

    logic [SCAN_W-1:0]  r_scan_cnt;
    logic [DIG_W-1:0]   r_dig_idx, w_dig_next;
    logic               w_scan_wrap;
    logic [EXT_W-1:0]   w_score_ext, w_target_ext;
    logic [DISP_W-1:0]  w_disp_src;
    logic [3:0]         w_nibble;
    logic [6:0]         w_seg, r_seg;
    logic [DIGITS-1:0]  w_dig_sel_next, r_dig_sel;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sw_meta     <= '0;
            r_sw_sync     <= '0;
            r_start_sync  <= '0;
            r_submit_sync <= '0;
            r_start_prev  <= 1'b0;
            r_submit_prev <= 1'b0;
            r_lfsr        <= LFSR_SEED;
        end else begin
            r_sw_meta     <= sw;
            r_sw_sync     <= r_sw_meta;
            r_start_sync  <= {r_start_sync[0], start};
            r_submit_sync <= {r_submit_sync[0], submit};
            r_start_prev  <= r_start_sync[1];
            r_submit_prev <= r_submit_sync[1];
            r_lfsr        <= lfsr_step(r_lfsr);
        end
    end

    assign w_start_edge  = r_start_sync[1]  & ~r_start_prev;
    assign w_submit_edge = r_submit_sync[1] & ~r_submit_prev;
    assign w_new_target  = (r_lfsr[WIDTH-1:0] == '0) ? WIDTH'(1) : r_lfsr[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_score    <= '0;
            r_target   <= '0;
            r_timer    <= '0;
            r_hold     <= '0;
            r_led_ok   <= 1'b0;
            r_led_fail <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_score    <= w_score;
            r_target   <= w_target;
            r_timer    <= w_timer;
            r_hold     <= w_hold;
            r_led_ok   <= w_led_ok;
            r_led_fail <= w_led_fail;
        end
    end

    // NOTE: every always_comb output gets its hold value first, so no path infers a latch.
    always_comb begin
        w_state    = r_state;
        w_score    = r_score;
        w_target   = r_target;
        w_timer    = r_timer;
        w_hold     = r_hold;
        w_led_ok   = r_led_ok;
        w_led_fail = r_led_fail;
        unique case (r_state)
            IDLE: begin
                if (w_start_edge) begin
                    w_score  = '0;
                    w_target = w_new_target;
                    w_timer  = TIMER_W'(ROUND_TICKS - 1);
                    w_state  = PLAY;
                end
            end
            PLAY: begin
                // A submit in the timer==0 cycle wins over the timeout.
                if (w_submit_edge) begin
                    if (r_sw_sync == r_target) begin
                        if (r_score != '1) w_score = r_score + 1'b1;
                        w_led_ok = 1'b1;
                    end else begin
                        w_led_fail = 1'b1;
                    end
                    w_hold  = HOLD_W'(RESULT_TICKS - 1);
                    w_state = RESULT;
                end else if (r_timer == '0) begin
                    w_led_fail = 1'b1;
                    w_hold     = HOLD_W'(RESULT_TICKS - 1);
                    w_state    = RESULT;
                end else begin
                    w_timer = r_timer - 1'b1;
                end
            end
            RESULT: begin
                if (r_hold == '0) begin
                    w_led_ok   = 1'b0;
                    w_led_fail = 1'b0;
                    if (r_led_ok) begin
                        w_target = w_new_target;
                        w_timer  = TIMER_W'(ROUND_TICKS - 1);
                        w_state  = PLAY;
                    end else begin
                        w_state = IDLE;
                    end
                end else begin
                    w_hold = r_hold - 1'b1;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    assign w_score_ext  = EXT_W'(r_score);
    assign w_target_ext = EXT_W'(r_target);
    assign w_disp_src   = (r_state == IDLE) ? w_score_ext[DISP_W-1:0] : w_target_ext[DISP_W-1:0];

    assign w_scan_wrap = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign w_dig_next  = !w_scan_wrap ? r_dig_idx :
                         (r_dig_idx == DIG_W'(DIGITS - 1)) ? '0 : r_dig_idx + 1'b1;

    // Digit select and nibble both come from the next index, so seg and dig_sel move together.
    always_comb begin
        w_nibble       = 4'h0;
        w_dig_sel_next = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_dig_next == DIG_W'(i)) begin
                w_nibble          = w_disp_src[4*i +: 4];
                w_dig_sel_next[i] = 1'b1;
            end
        end
    end

    sevenseg_decoder u_dec (
        .i_hex (w_nibble),
        .o_seg (w_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_dig_idx  <= '0;
            r_seg      <= SEG_BLANK;
            r_dig_sel  <= DIGITS'(1);
        end else begin
            r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + 1'b1;
            r_dig_idx  <= w_dig_next;
            r_seg      <= w_seg;
            r_dig_sel  <= w_dig_sel_next;
        end
    end

    assign seg      = r_seg;
    assign dig_sel  = r_dig_sel;
    assign led_ok   = r_led_ok;
    assign led_fail = r_led_fail;
    assign score    = r_score;
    assign playing  = (r_state == PLAY);

endmodule

// File: tb/tb_binary_quiz_core.sv
// Self-checking bench: two cores (8-bit and 3-bit score) share one stimulus and are
// compared against a round-level game model and an independent LFSR/segment reference.
module tb_binary_quiz_core;

    localparam int WIDTH = 8;
    localparam int RT    = 20;
    localparam int RS    = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sw;
    logic       start, submit;

    logic [6:0] seg8, seg3;
    logic [1:0] dsel8, dsel3;
    logic       ok8, fail8, play8, ok3, fail3, play3;
    logic [7:0] score8;
    logic [2:0] score3;
    logic [3:0] dec_in;
    logic [6:0] dec_out;

    binary_quiz_core #(.WIDTH(8), .DIGITS(2), .SCORE_W(8), .ROUND_TICKS(RT),
                       .RESULT_TICKS(RS), .SCAN_DIV(4)) dut8 (
        .clk(clk), .rst(rst), .sw(sw), .start(start), .submit(submit),
        .seg(seg8), .dig_sel(dsel8), .led_ok(ok8), .led_fail(fail8),
        .score(score8), .playing(play8));

    binary_quiz_core #(.WIDTH(8), .DIGITS(2), .SCORE_W(3), .ROUND_TICKS(RT),
                       .RESULT_TICKS(RS), .SCAN_DIV(4)) dut3 (
        .clk(clk), .rst(rst), .sw(sw), .start(start), .submit(submit),
        .seg(seg3), .dig_sel(dsel3), .led_ok(ok3), .led_fail(fail3),
        .score(score3), .playing(play3));

    sevenseg_decoder u_dec (.i_hex(dec_in), .o_seg(dec_out));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct {
        logic [3:0] hex;
        logic [6:0] seg;
    } dec_vec_t;
    dec_vec_t vecs [16];

    // Reference LFSR built from the polynomial exponents x^16+x^14+x^13+x^11.
    function automatic logic [15:0] ref_step(input logic [15:0] v);
        int         taps [4] = '{16, 14, 13, 11};
        logic [15:0] mask = '0;
        foreach (taps[i]) mask = mask | (16'(1) << (taps[i] - 1));
        return v[0] ? ((v >> 1) ^ mask) : (v >> 1);
    endfunction

    function automatic logic [7:0] ref_target(input logic [15:0] v);
        return (v[7:0] == 8'h00) ? 8'h01 : v[7:0];
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    logic [15:0] m_lfsr;
    logic [7:0]  m_target;
    int          m_count;

    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr = 16'hACE1;
        else     m_lfsr = ref_step(m_lfsr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_score(input string tag);
        check({tag, " score8"}, 32'(score8), 32'(sat(m_count, 255)));
        check({tag, " score3"}, 32'(score3), 32'(sat(m_count, 7)));
    endtask

    // Starting from IDLE: pulse start, expect PLAY exactly 3 clocks after the pin rise.
    task automatic start_game();
        m_target = ref_target(ref_step(ref_step(m_lfsr)));
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        tick();
        m_count = 0;
        check("start playing8", 32'(play8), 1);
        check("start playing3", 32'(play3), 1);
        check("start target", 32'(dut8.r_target), 32'(m_target));
        check_score("start");
    endtask

    // Starting at the first PLAY cycle: kind 0 correct, 1 wrong, 2 timeout; d = ticks before submit.
    task automatic play_round(input int kind, input int d);
        logic       ok_exp;
        logic [7:0] next_t;
        next_t = 8'h00;
        ok_exp = (kind == 0);
        if (kind == 2) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            ticks(RT - 2);
            check("timer0 still playing", 32'(play8), 1);
            check("timer0 no led", 32'({ok8, fail8}), 0);
            tick();
        end else begin
            if (d >= 3) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                ticks(d - 1);
            end else begin
                ticks(d);
            end
            sw = (kind == 0) ? m_target : (m_target ^ 8'($urandom_range(1, 255)));
            submit = 1'b1;
            tick();
            tick();
            submit = 1'b0;
            check("pre-result playing", 32'(play8), 1);
            tick();
        end
        if (ok_exp) m_count++;
        for (int i = 0; i < RS; i++) begin
            check("result led_ok", 32'({ok8, ok3}), ok_exp ? 32'd3 : 32'd0);
            check("result led_fail", 32'({fail8, fail3}), ok_exp ? 32'd0 : 32'd3);
            if (i == 0) begin
                check("result playing", 32'(play8), 0);
                check_score("result");
            end
            if (i == RS - 1) next_t = ref_target(m_lfsr);
            tick();
        end
        check("after leds clear", 32'({ok8, fail8, ok3, fail3}), 0);
        check("after playing", 32'({play8, play3}), ok_exp ? 32'd3 : 32'd0);
        if (ok_exp) begin
            m_target = next_t;
            check("new target", 32'(dut8.r_target), 32'(m_target));
        end
        check_score("after");
    endtask

    // Both cores must show v8/v3 (low nibble on digit 0, high on digit 1) over a few scan periods.
    task automatic check_display(input string tag, input logic [7:0] v8, input logic [7:0] v3);
        for (int i = 0; i < 8; i++) begin
            check({tag, " seg8"}, 32'(seg8), 32'(seg_tab[(dsel8 == 2'b01) ? v8[3:0] : v8[7:4]]));
            check({tag, " seg3"}, 32'(seg3), 32'(seg_tab[(dsel3 == 2'b01) ? v3[3:0] : v3[7:4]]));
            tick();
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int run;
        int seen;
        int found;
        logic [1:0] prev;

        rst = 1'b1; sw = 8'h00; start = 1'b0; submit = 1'b0; m_count = 0;
        for (int i = 0; i < 16; i++) begin
            vecs[i].hex = 4'(i);
            vecs[i].seg = seg_tab[i];
        end

        // Decoder table.
        for (int i = 0; i < 16; i++) begin
            dec_in = vecs[i].hex;
            #1;
            check("decoder", 32'(dec_out), 32'(vecs[i].seg));
        end

        ticks(2);
        check("reset seg", 32'({seg8, seg3}), 0);
        check("reset dig_sel", 32'({dsel8, dsel3}), 32'h5);
        check("reset score", 32'({score8, score3}), 0);
        check("reset flags", 32'({play8, ok8, fail8, play3, ok3, fail3}), 0);
        rst = 1'b0;
        ticks(3);

        // Asynchronous reset in the middle of a round.
        start_game();
        ticks(5);
        #3;
        rst = 1'b1;
        #1;
        check("midreset seg", 32'({seg8, seg3}), 0);
        check("midreset dig_sel", 32'({dsel8, dsel3}), 32'h5);
        check("midreset score", 32'({score8, score3}), 0);
        check("midreset flags", 32'({play8, ok8, fail8, play3, ok3, fail3}), 0);
        tick();
        rst = 1'b0;
        m_count = 0;
        ticks(2);

        // Correct, then wrong (score kept), restart clears score.
        start_game();
        play_round(0, 4);
        play_round(1, 2);
        check_score("game over kept");
        ticks(2);
        start_game();

        // Timeout, then submit exactly in the timer==0 cycle.
        play_round(2, 0);
        start_game();
        play_round(0, RT - 3);
        play_round(2, 0);

        // Wait in IDLE until the model predicts target A5, then check the scan.
        found = 0;
        for (int i = 0; i < 5000 && found == 0; i++) begin
            if (ref_target(ref_step(ref_step(m_lfsr))) == 8'hA5) found = 1;
            else tick();
        end
        check("a5 search found", 32'(found), 1);
        start_game();
        check("scan target", 32'(dut8.r_target), 32'hA5);
        tick();
        prev = dsel8;
        run  = 1;
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            check("scan onehot", 32'((dsel8 == 2'b01) || (dsel8 == 2'b10)), 1);
            check("scan seg", 32'(seg8), 32'((dsel8 == 2'b01) ? seg_tab[5] : seg_tab[10]));
            tick();
            if (dsel8 == prev) run++;
            else begin
                if (seen != 0) check("scan period", 32'(run), 4);
                seen = 1;
                run  = 1;
                prev = dsel8;
            end
        end
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            if (play8 == 1'b0) found = 1;
            else tick();
        end
        check("scan round timeout", 32'({found[0], fail8}), 32'h3);
        ticks(RS + 1);
        check("scan back idle", 32'({play8, ok8, fail8}), 0);

        // Saturation: nine correct rounds; 3-bit score sticks at 7 while play continues.
        start_game();
        for (int i = 0; i < 9; i++) play_round(0, $urandom_range(0, RT - 3));
        check("sat playing", 32'(play3), 1);
        play_round(1, 1);
        ticks(1);
        check_display("idle score", 8'h09, 8'h07);

        // Randomised games against the round-level model.
        for (int g = 0; g < 30; g++) begin
            int kind;
            if (play8 == 1'b0) begin
                sw = 8'($urandom);
                submit = 1'b1;
                ticks(2);
                submit = 1'b0;
                ticks(2);
                check("idle submit ignored", 32'({play8, ok8, fail8}), 0);
                start_game();
            end
            kind = $urandom_range(0, 9);
            kind = (kind < 6) ? 0 : (kind < 8) ? 1 : 2;
            play_round(kind, $urandom_range(0, RT - 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
